a2d_arbiter: RTL

A2D_ARBITER -- requirements
Module: a2d_arbiter

---
 rtl/a2d_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/a2d_arbiter.sv
// ============================================================================
// Module   : a2d_arbiter
// Purpose  : Round-robin arbiter sharing one A2D converter among three
//            requesters. Includes a conversion timeout.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module a2d_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [8:0]  chnnl_req,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [11:0] res_out,
  output logic        timeout_err,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res
);

  localparam int c_TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_ptr, w_ptr_nxt;
  logic [1:0]           r_owner, w_owner_nxt;
  logic [c_TMR_W-1:0]   r_timer, w_timer_nxt;
  logic [2:0]           r_gnt, w_gnt_nxt;
  logic [2:0]           r_done, w_done_nxt;
  logic [11:0]          r_res_out, w_res_nxt;
  logic                 r_to, w_to_nxt;
  logic                 r_strt, w_strt_nxt;
  logic [2:0]           r_chnnl, w_chnnl_nxt;

  logic                 w_win_vld;
  logic [1:0]           w_win;
  logic [1:0]           w_idx;
  logic [2:0]           w_win_chnnl;

  function automatic logic [1:0] f_inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Scan ptr, ptr+1, ptr+2 (mod 3); the first requester found wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 2'd0;
    w_idx     = r_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!w_win_vld && req[w_idx]) begin
        w_win_vld = 1'b1;
        w_win     = w_idx;
      end
      w_idx = f_inc3(w_idx);
    end
  end

  always_comb begin
    w_win_chnnl = chnnl_req[2:0];
    case (w_win)
      2'd1:    w_win_chnnl = chnnl_req[5:3];
      2'd2:    w_win_chnnl = chnnl_req[8:6];
      default: w_win_chnnl = chnnl_req[2:0];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_timer_nxt = r_timer;
    w_gnt_nxt   = r_gnt;
    w_chnnl_nxt = r_chnnl;
    w_res_nxt   = r_res_out;
    w_done_nxt  = 3'b000;
    w_to_nxt    = 1'b0;
    w_strt_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = 3'b000;
        if (w_win_vld) begin
          w_gnt_nxt   = 3'b001 << w_win;
          w_owner_nxt = w_win;
          w_chnnl_nxt = w_win_chnnl;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_strt_nxt  = 1'b1;
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a timeout landing in the same clock.
        if (cnv_cmplt) begin
          w_res_nxt   = res;
          w_done_nxt  = r_gnt & req;
          w_gnt_nxt   = 3'b000;
          w_ptr_nxt   = f_inc3(r_owner);
          w_state_nxt = S_IDLE;
        end else if (r_timer == c_TMR_LAST) begin
          w_to_nxt    = 1'b1;
          w_gnt_nxt   = 3'b000;
          w_ptr_nxt   = f_inc3(r_owner);
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_gnt_nxt   = 3'b000;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_timer   <= '0;
      r_gnt     <= 3'b000;
      r_done    <= 3'b000;
      r_res_out <= 12'h000;
      r_to      <= 1'b0;
      r_strt    <= 1'b0;
      r_chnnl   <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_timer   <= w_timer_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_res_out <= w_res_nxt;
      r_to      <= w_to_nxt;
      r_strt    <= w_strt_nxt;
      r_chnnl   <= w_chnnl_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign res_out     = r_res_out;
  assign timeout_err = r_to;
  assign strt_cnv    = r_strt;
  assign chnnl       = r_chnnl;

endmodule

`default_nettype wire
